tlbram_plru: RTL and testbench
==============================

# tlbram_plru

Parametrised successor TLB storage array for the MMU: holds per-entry page table entries with valid bits, selects the matching entry's PPN and access bits, and owns replacement and invalidation. Adds features the plain flop-array TLB RAM lacks:
- a tree pseudo-LRU victim selector with invalid-first fill;
- global and non-global flush;
- an optional registered read stage;
- multi-hit detection.

It sits between the TLB CAM (which supplies `Matches`) and the TLB controller / page-table walker (which supplies fills and flushes).

## Interface
Parameters:
- `TLB_ENTRIES`, 8, number of entries; power of two, at least 2.
- `REG_OUT`, 1, 0 = combinational read; 1 = read outputs registered with one cycle of latency.
- `XLEN` and `PPN_BITS` come from `config_pkg`.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `PTE`  in  XLEN  fill data.
- `Matches`  in  TLB_ENTRIES  one-hot CAM match vector.
- `ReadEn`  in  1  lookup qualifier; updates PLRU state on a hit.
- `WriteEn`  in  1  fill request; the entry is chosen internally.
- `FlushAll`  in  1  invalidate every entry.
- `FlushNonGlobal`  in  1  invalidate entries with G=0.
- `Hit`  out  1  a valid entry matched.
- `MultiHit`  out  1  more than one valid entry matched (error).
- `PPN`  out  PPN_BITS  `PTE[PPN_BITS+9:10]` of the hit entry.
- `PTEAccessBits`  out  12  RV64: `{PTE[XLEN-1:XLEN-4], PTE[7:0]}`; RV32: `{4'b0, PTE[7:0]}`.
- `Valids`  out  TLB_ENTRIES  per-entry valid bits.
- `PTE_Gs`  out  TLB_ENTRIES  per-entry G bit (`PTE[5]`) AND valid.
- `PTE_NAPOTs`  out  TLB_ENTRIES  per-entry valid AND XLEN==64 AND `PTE[63]` AND `PTE[13:10]==4'b1000`.
- `VictimOneHot`  out  TLB_ENTRIES  entry the next fill will write.

## Operation
- **State:**
  - `TLB_ENTRIES` PTE registers;
  - `TLB_ENTRIES` valid bits;
  - `TLB_ENTRIES-1` PLRU tree bits.
- **Reset:**
  - all PTEs, valid bits and PLRU bits are 0;
  - `Hit`, `MultiHit`, `PPN` and `PTEAccessBits` are 0;
  - `VictimOneHot` = entry 0.
- **Lookup:**
  - HitVec = `Matches` & `Valids`;
  - `Hit` = |HitVec;
  - `MultiHit` = popcount(HitVec) > 1;
  - read data = OR of the PTEs selected by HitVec, so all-zero when there is no hit.
- **Victim:**
  - the lowest-index invalid entry if any entry is invalid;
  - otherwise the entry the PLRU tree points to.
- **Fill:** with `WriteEn`=1, the victim entry loads `PTE` and its valid bit is set at the next clock edge.
- **PLRU touch:**
  - on a fill, the tree bits along the written entry's path point away from it;
  - otherwise, on `ReadEn` & `Hit` & !`MultiHit`, the tree bits point away from the hit entry;
  - a fill touch has priority over a hit touch in the same cycle (the hit touch is dropped).
- **Flush:**
  - `FlushAll` clears all valid bits and the PLRU bits;
  - `FlushNonGlobal` clears only the valid bits of entries whose stored G=0;
  - PTE contents are not cleared;
  - `FlushAll` dominates if both flushes are asserted.
- **Flush + fill in the same cycle:**
  - the victim is computed from pre-flush state;
  - the flush applies to all other entries;
  - the filled entry ends valid with the new data (fill wins).
- **MultiHit:** the read data is still the OR of the matching entries; the PLRU is not updated.

## Timing
- `REG_OUT`=0: `Hit`, `MultiHit`, `PPN` and `PTEAccessBits` are combinational from `Matches` in the same cycle.
- `REG_OUT`=1:
  - these outputs register the cycle-N lookup and are valid in cycle N+1;
  - they update every cycle, independent of `ReadEn`.
- `Valids`, `PTE_Gs`, `PTE_NAPOTs` and `VictimOneHot` are combinational from the current state in all modes.
- A fill in cycle N is visible to a lookup in cycle N+1; there is no write-through bypass in cycle N.
- A flush in cycle N makes the affected entries miss from cycle N+1.
- Reset assertion is asynchronous: all state and registered outputs go to their reset values immediately. Deassertion is synchronised externally.

## Structure
- `config_pkg` supplies `XLEN` and `PPN_BITS`.
- New package constants: PTE field positions `PTE_G_BIT`=5, `PTE_N_BIT`=63 and `PTE_PPN_LSB`=10.
- One sub-module, `tlbplru`:
  - parameter `TLB_ENTRIES`;
  - inputs `clk`, `reset`, `TouchEn`, `TouchOneHot`, `Clear`;
  - output `PLRUVictimOneHot`;
  - implements the tree bits, touch and victim decode.
- The entry array, valid bits, flush, invalid-first priority and the OR read logic stay in `tlbram_plru`.

## Test plan
- **Reset, then fill ×8 (`TLB_ENTRIES`=8), PTE = 0x1000_0000_0000_2C01 + (i<<10):** fills land in entries 0..7 in order; `Valids`=0xFF afterwards.
- **Full array, then lookups:**
  - hit entries 0,1,2,3 with `ReadEn`=1;
  - the next fill writes entry 4, per tree PLRU after touches 0,1,2,3;
  - with `Matches`=0x10 in the following cycle, `Hit`=1 and `PPN` equals the new PTE[PPN_BITS+9:10].
- **`REG_OUT`=1:** `Matches`=0x04 in cycle N → `Hit`/`PPN` valid in N+1; `Matches`=0 in N+1 → `Hit`=0 and `PPN`=0 in N+2.
- **Global/non-global flush:**
  - entries 2 and 5 have G=1;
  - `FlushNonGlobal` → `Valids`=0x24 next cycle;
  - the next fill writes entry 0;
  - `FlushAll` → `Valids`=0.
- **Flush + fill in the same cycle on a full array:** only the victim entry is valid afterwards; `Valids` is one-hot equal to the prior `VictimOneHot`.
- **Multi-hit and asynchronous reset:**
  - `Matches`=0x03 with both entries valid → `MultiHit`=1 and the PLRU is unchanged;
  - asserting `reset` low mid-cycle zeroes `Valids` and `Hit` before the next edge.

Source files
------------

// File: rtl/config_pkg.sv
// Core configuration shared across the MMU: datapath width and physical page number width.
package config_pkg;

    localparam int XLEN     = 64;
    localparam int PPN_BITS = 44;

endpackage

// File: rtl/tlbram_plru_pkg.sv
// PTE field positions and flush classification used by the PLRU TLB storage array.
package tlbram_plru_pkg;

    localparam int PTE_G_BIT   = 5;
    localparam int PTE_N_BIT   = 63;
    localparam int PTE_PPN_LSB = 10;
    localparam int ACCESS_BITS = 12;

    // PPN[3:0] encoding that marks a 64 KiB NAPOT mapping
    localparam logic [3:0] NAPOT_64K_ENC = 4'b1000;

    typedef enum logic [1:0] {
        FLUSH_NONE      = 2'b00,
        FLUSH_NONGLOBAL = 2'b01,
        FLUSH_ALL       = 2'b10
    } flush_e;

    function automatic flush_e flush_kind(input logic flush_all, input logic flush_nonglobal);
        flush_e kind;
        if (flush_all) begin
            kind = FLUSH_ALL;
        end else if (flush_nonglobal) begin
            kind = FLUSH_NONGLOBAL;
        end else begin
            kind = FLUSH_NONE;
        end
        return kind;
    endfunction

    function automatic logic is_napot64k(input logic [3:0] ppn_low);
        return (ppn_low == NAPOT_64K_ENC);
    endfunction

endpackage

// File: rtl/tlbram_plru_tlbplru.sv
// Tree pseudo-LRU for the TLB: one bit per internal node, 1 means the victim lies in
// the right subtree. A touch flips every node on the entry's path to point away from it.
module tlbplru #(
    parameter int TLB_ENTRIES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   TouchEn,
    input  logic [TLB_ENTRIES-1:0] TouchOneHot,
    input  logic                   Clear,
    output logic [TLB_ENTRIES-1:0] PLRUVictimOneHot
);

    localparam int LOGN  = $clog2(TLB_ENTRIES);
    localparam int NODES = TLB_ENTRIES - 1;

    logic [NODES-1:0] tree_q;
    logic [NODES-1:0] tree_d;
    logic [NODES-1:0] in_left_s;
    logic [NODES-1:0] in_right_s;

    // Node n at level l, position k covers entries [k*span, (k+1)*span)
    for (genvar l = 0; l < LOGN; l++) begin : g_lvl
        for (genvar k = 0; k < (1 << l); k++) begin : g_node
            localparam int NODE = (1 << l) - 1 + k;
            localparam int SPAN = TLB_ENTRIES >> l;
            localparam int HALF = SPAN / 2;
            localparam int BASE = k * SPAN;
            assign in_left_s[NODE]  = |TouchOneHot[BASE +: HALF];
            assign in_right_s[NODE] = |TouchOneHot[BASE + HALF +: HALF];
        end
    end

    // Clear first, then a touch in the same cycle still marks its path
    always_comb begin
        if (Clear) begin
            tree_d = '0;
        end else begin
            tree_d = tree_q;
        end
        for (int n = 0; n < NODES; n++) begin
            if (TouchEn && in_left_s[n]) begin
                tree_d[n] = 1'b1;
            end else if (TouchEn && in_right_s[n]) begin
                tree_d[n] = 1'b0;
            end else begin
                tree_d[n] = tree_d[n];
            end
        end
    end

    // Tree state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tree_q <= '0;
        end else begin
            tree_q <= tree_d;
        end
    end

    // An entry is the victim when every node on its path points toward it
    for (genvar e = 0; e < TLB_ENTRIES; e++) begin : g_ent
        logic [LOGN-1:0] path_ok_s;
        for (genvar l = 0; l < LOGN; l++) begin : g_step
            localparam int   NODE = (1 << l) - 1 + (e >> (LOGN - l));
            localparam logic DIR  = (((e >> (LOGN - 1 - l)) % 2) != 0);
            assign path_ok_s[l] = (tree_q[NODE] == DIR);
        end
        assign PLRUVictimOneHot[e] = &path_ok_s;
    end

endmodule

// File: rtl/tlbram_plru.sv
// TLB storage array: PTE registers with valid bits, OR-based hit read, multi-hit detection,
// global/non-global flush and invalid-first victim selection backed by a tree PLRU.
module tlbram_plru
    import config_pkg::*;
    import tlbram_plru_pkg::*;
#(
    parameter int TLB_ENTRIES = 8,
    parameter bit REG_OUT     = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [XLEN-1:0]        PTE,
    input  logic [TLB_ENTRIES-1:0] Matches,
    input  logic                   ReadEn,
    input  logic                   WriteEn,
    input  logic                   FlushAll,
    input  logic                   FlushNonGlobal,
    output logic                   Hit,
    output logic                   MultiHit,
    output logic [PPN_BITS-1:0]    PPN,
    output logic [ACCESS_BITS-1:0] PTEAccessBits,
    output logic [TLB_ENTRIES-1:0] Valids,
    output logic [TLB_ENTRIES-1:0] PTE_Gs,
    output logic [TLB_ENTRIES-1:0] PTE_NAPOTs,
    output logic [TLB_ENTRIES-1:0] VictimOneHot
);

    localparam logic [TLB_ENTRIES-1:0] LSB_ONE = {{(TLB_ENTRIES-1){1'b0}}, 1'b1};

    logic [XLEN-1:0]        pte_q [TLB_ENTRIES];
    logic [TLB_ENTRIES-1:0] valid_q;
    logic [TLB_ENTRIES-1:0] valid_d;
    logic [TLB_ENTRIES-1:0] hit_vec_s;
    logic [TLB_ENTRIES-1:0] g_bits_s;
    logic [TLB_ENTRIES-1:0] napot_s;
    logic [TLB_ENTRIES-1:0] invalid_s;
    logic [TLB_ENTRIES-1:0] first_inv_s;
    logic [TLB_ENTRIES-1:0] plru_victim_s;
    logic [TLB_ENTRIES-1:0] victim_s;
    logic [TLB_ENTRIES-1:0] touch_oh_s;
    logic                   hit_s;
    logic                   multi_hit_s;
    logic                   touch_en_s;
    logic                   clear_s;
    logic [XLEN-1:0]        rd_data_s;
    logic [PPN_BITS-1:0]    ppn_s;
    logic [ACCESS_BITS-1:0] acc_s;
    logic                   rd_unused_s;
    flush_e                 flush_s;

    assign flush_s = flush_kind(FlushAll, FlushNonGlobal);
    assign clear_s = (flush_s == FLUSH_ALL);

    // Stored G bit of every entry, independent of validity
    always_comb begin
        g_bits_s = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            g_bits_s[i] = pte_q[i][PTE_G_BIT];
        end
    end

    if (XLEN == 64) begin : g_napot
        // NAPOT flag per valid entry
        always_comb begin
            napot_s = '0;
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                napot_s[i] = valid_q[i] & pte_q[i][PTE_N_BIT] & is_napot64k(pte_q[i][PTE_PPN_LSB +: 4]);
            end
        end
        assign acc_s = {rd_data_s[XLEN-1 -: 4], rd_data_s[7:0]};
    end else begin : g_no_napot
        assign napot_s = '0;
        assign acc_s   = {4'b0000, rd_data_s[7:0]};
    end

    // Lookup: OR of hitting entries, so a miss reads as all zeros
    always_comb begin
        hit_vec_s   = Matches & valid_q;
        hit_s       = |hit_vec_s;
        multi_hit_s = |(hit_vec_s & (hit_vec_s - LSB_ONE));
        rd_data_s   = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            rd_data_s = rd_data_s | (pte_q[i] & {XLEN{hit_vec_s[i]}});
        end
    end

    assign ppn_s       = rd_data_s[PTE_PPN_LSB +: PPN_BITS];
    assign rd_unused_s = ^rd_data_s;

    // Invalid-first victim: isolate lowest set bit of the invalid mask
    always_comb begin
        invalid_s   = ~valid_q;
        first_inv_s = invalid_s & (~invalid_s + LSB_ONE);
        if (|invalid_s) begin
            victim_s = first_inv_s;
        end else begin
            victim_s = plru_victim_s;
        end
    end

    // A fill touch takes priority and masks any concurrent hit touch
    always_comb begin
        if (WriteEn) begin
            touch_en_s = 1'b1;
            touch_oh_s = victim_s;
        end else begin
            touch_en_s = ReadEn & hit_s & ~multi_hit_s;
            touch_oh_s = hit_vec_s;
        end
    end

    // Valid next-state: flush first, fill overrides for the victim slot
    always_comb begin
        case (flush_s)
            FLUSH_ALL:       valid_d = '0;
            FLUSH_NONGLOBAL: valid_d = valid_q & g_bits_s;
            default:         valid_d = valid_q;
        endcase
        if (WriteEn) begin
            valid_d = valid_d | victim_s;
        end else begin
            valid_d = valid_d;
        end
    end

    // Entry storage: only the victim slot loads on a fill
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                pte_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                if (WriteEn && victim_s[i]) begin
                    pte_q[i] <= PTE;
                end
            end
            valid_q <= valid_d;
        end
    end

    tlbplru #(
        .TLB_ENTRIES (TLB_ENTRIES)
    ) u_plru (
        .clk              (clk),
        .reset            (reset),
        .TouchEn          (touch_en_s),
        .TouchOneHot      (touch_oh_s),
        .Clear            (clear_s),
        .PLRUVictimOneHot (plru_victim_s)
    );

    if (REG_OUT) begin : g_reg_out
        logic                   hit_q;
        logic                   multi_hit_q;
        logic [PPN_BITS-1:0]    ppn_q;
        logic [ACCESS_BITS-1:0] acc_q;

        // Read stage: captures every cycle's lookup regardless of ReadEn
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                hit_q       <= 1'b0;
                multi_hit_q <= 1'b0;
                ppn_q       <= '0;
                acc_q       <= '0;
            end else begin
                hit_q       <= hit_s;
                multi_hit_q <= multi_hit_s;
                ppn_q       <= ppn_s;
                acc_q       <= acc_s;
            end
        end

        assign Hit           = hit_q;
        assign MultiHit      = multi_hit_q;
        assign PPN           = ppn_q;
        assign PTEAccessBits = acc_q;
    end else begin : g_comb_out
        assign Hit           = hit_s;
        assign MultiHit      = multi_hit_s;
        assign PPN           = ppn_s;
        assign PTEAccessBits = acc_s;
    end

    assign Valids       = valid_q;
    assign PTE_Gs       = g_bits_s & valid_q;
    assign PTE_NAPOTs   = napot_s;
    assign VictimOneHot = victim_s;

endmodule

// File: tb/tb_tlbram_plru.sv
// Scoreboard bench for tlbram_plru: a registered-output and a combinational-output instance
// share one stimulus stream and are compared against a timestamp-based LRU-tree model.
module tb_tlbram_plru;
    import config_pkg::*;

    localparam int N = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] PTE;
    logic [N-1:0]    Matches;
    logic            ReadEn, WriteEn, FlushAll, FlushNonGlobal;

    logic                hit_r, multi_r, hit_c, multi_c;
    logic [PPN_BITS-1:0] ppn_r, ppn_c;
    logic [11:0]         acc_r, acc_c;
    logic [N-1:0]        valids_r, gs_r, napots_r, victim_r;
    logic [N-1:0]        valids_c, gs_c, napots_c, victim_c;

    tlbram_plru #(.TLB_ENTRIES(N), .REG_OUT(1'b1)) u_dut (
        .clk(clk), .reset(reset), .PTE(PTE), .Matches(Matches), .ReadEn(ReadEn),
        .WriteEn(WriteEn), .FlushAll(FlushAll), .FlushNonGlobal(FlushNonGlobal),
        .Hit(hit_r), .MultiHit(multi_r), .PPN(ppn_r), .PTEAccessBits(acc_r),
        .Valids(valids_r), .PTE_Gs(gs_r), .PTE_NAPOTs(napots_r), .VictimOneHot(victim_r));

    tlbram_plru #(.TLB_ENTRIES(N), .REG_OUT(1'b0)) u_comb (
        .clk(clk), .reset(reset), .PTE(PTE), .Matches(Matches), .ReadEn(ReadEn),
        .WriteEn(WriteEn), .FlushAll(FlushAll), .FlushNonGlobal(FlushNonGlobal),
        .Hit(hit_c), .MultiHit(multi_c), .PPN(ppn_c), .PTEAccessBits(acc_c),
        .Valids(valids_c), .PTE_Gs(gs_c), .PTE_NAPOTs(napots_c), .VictimOneHot(victim_c));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: contents, validity and a last-touch timestamp per entry
    logic [63:0] m_pte [N];
    bit          m_valid [N];
    int          m_stamp [N];
    int          tick;

    typedef struct {
        int                  cyc;
        logic                hit;
        logic                multi;
        logic [PPN_BITS-1:0] ppn;
        logic [11:0]         acc;
        logic [N-1:0]        valids;
        logic [N-1:0]        gs;
        logic [N-1:0]        napots;
        logic [N-1:0]        victim;
    } exp_t;

    exp_t comb_q[$];
    exp_t reg_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Lowest invalid entry, else descend toward the half whose newest touch is older
    function automatic int m_victim();
        int lo, size, half, ml, mr;
        for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
        lo = 0;
        size = N;
        while (size > 1) begin
            half = size / 2;
            ml = 0;
            mr = 0;
            for (int j = 0; j < half; j++) begin
                if (m_stamp[lo + j] > ml) ml = m_stamp[lo + j];
                if (m_stamp[lo + half + j] > mr) mr = m_stamp[lo + half + j];
            end
            if (ml > mr) lo = lo + half;
            size = half;
        end
        return lo;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pte[i] = '0;
            m_valid[i] = 1'b0;
            m_stamp[i] = 0;
        end
        tick = 0;
    endtask

    task automatic step(input logic [N-1:0] m, input logic re, input logic we,
                        input logic fa, input logic fng, input logic [63:0] d);
        exp_t        e;
        logic [63:0] rd;
        int          cnt, hidx, v;
        @(posedge clk);
        #1;
        Matches = m; ReadEn = re; WriteEn = we; FlushAll = fa; FlushNonGlobal = fng; PTE = d;
        rd = '0; cnt = 0; hidx = 0;
        v = m_victim();
        e.victim = '0;
        e.victim[v] = 1'b1;
        for (int i = 0; i < N; i++) begin
            e.valids[i] = m_valid[i];
            e.gs[i]     = m_valid[i] & m_pte[i][5];
            e.napots[i] = m_valid[i] && m_pte[i][63] && (m_pte[i][13:10] == 4'b1000);
            if (m[i] && m_valid[i]) begin
                cnt++;
                hidx = i;
                rd = rd | m_pte[i];
            end
        end
        e.cyc   = cyc;
        e.hit   = (cnt > 0);
        e.multi = (cnt > 1);
        e.ppn   = rd[PPN_BITS+9:10];
        e.acc   = {rd[63:60], rd[7:0]};
        comb_q.push_back(e);
        reg_q.push_back(e);
        if (fa) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 1'b0;
                m_stamp[i] = 0;
            end
        end else if (fng) begin
            for (int i = 0; i < N; i++) if (!m_pte[i][5]) m_valid[i] = 1'b0;
        end
        if (we) begin
            m_pte[v] = d;
            m_valid[v] = 1'b1;
            tick++;
            m_stamp[v] = tick;
        end else if (re && cnt == 1) begin
            tick++;
            m_stamp[hidx] = tick;
        end
    endtask

    task automatic idle();
        step('0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic fill(input logic [63:0] d);
        step('0, 1'b0, 1'b1, 1'b0, 1'b0, d);
    endtask

    // Monitor: state/combinational results same cycle, registered results one cycle later
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (comb_q.size() > 0 && comb_q[0].cyc == cyc) begin
                e = comb_q.pop_front();
                check("valids", valids_r, e.valids);
                check("pte_gs", gs_r, e.gs);
                check("napots", napots_r, e.napots);
                check("victim", victim_r, e.victim);
                check("comb_valids", valids_c, e.valids);
                check("comb_hit", hit_c, e.hit);
                check("comb_multihit", multi_c, e.multi);
                check("comb_ppn", ppn_c, e.ppn);
                check("comb_access", acc_c, e.acc);
            end
            if (reg_q.size() > 0 && reg_q[0].cyc == cyc - 1) begin
                e = reg_q.pop_front();
                check("reg_hit", hit_r, e.hit);
                check("reg_multihit", multi_r, e.multi);
                check("reg_ppn", ppn_r, e.ppn);
                check("reg_access", acc_r, e.acc);
            end
        end
    end

    initial begin
        logic [63:0]  d;
        logic [N-1:0] pv, m, oh;
        int           v, r;
        reset = 1'b0;
        PTE = '0; Matches = '0; ReadEn = 1'b0; WriteEn = 1'b0; FlushAll = 1'b0; FlushNonGlobal = 1'b0;
        model_reset();
        #12;
        check("reset_valids", valids_r, 8'h00);
        check("reset_victim", victim_r, 8'h01);
        check("reset_hit", hit_r, 1'b0);
        check("reset_multihit", multi_r, 1'b0);
        check("reset_ppn", ppn_r, 44'h0);
        check("reset_access", acc_r, 12'h000);
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < N; i++) fill(64'h1000_0000_0000_2C01 + (64'(i) << 10));
        idle();
        #1 check("fill_all_valids", valids_r, 8'hFF);

        for (int i = 0; i < 4; i++) begin
            oh = '0;
            oh[i] = 1'b1;
            step(oh, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        end
        idle();
        #1 check("plru_after_touch", victim_r, 8'h10);
        d = {$urandom, $urandom};
        fill(d);
        step(8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        idle();
        #1 check("refill_hit", hit_r, 1'b1);
        check("refill_ppn", ppn_r, d[PPN_BITS+9:10]);

        step(8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        idle();
        #1 check("regout_hit_n1", hit_r, 1'b1);
        check("regout_ppn_n1", ppn_r, 44'hD);
        idle();
        #1 check("regout_hit_n2", hit_r, 1'b0);
        check("regout_ppn_n2", ppn_r, 44'h0);

        step('0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        for (int i = 0; i < N; i++) begin
            d = {$urandom, $urandom};
            d[5] = (i == 2 || i == 5);
            fill(d);
        end
        step('0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
        idle();
        #1 check("fng_valids", valids_r, 8'h24);
        check("fng_victim", victim_r, 8'h01);
        step('0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
        idle();
        #1 check("flushall_valids", valids_r, 8'h00);

        for (int i = 0; i < N; i++) fill({$urandom, $urandom});
        idle();
        #1 pv = victim_r;
        step('0, 1'b0, 1'b1, 1'b1, 1'b0, {$urandom, $urandom});
        idle();
        #1 check("flush_fill_valids", valids_r, pv);

        for (int i = 0; i < N - 1; i++) fill({$urandom, $urandom});
        idle();
        #1 pv = victim_r;
        step(8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        idle();
        #1 check("multihit_flag", multi_r, 1'b1);
        check("multihit_plru_kept", victim_r, pv);

        repeat (600) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                m = '0;
                m[$urandom_range(0, N - 1)] = 1'b1;
            end else if (r < 75) begin
                m = '0;
            end else begin
                m = N'($urandom);
            end
            d = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) begin
                d[63] = 1'b1;
                d[13:10] = 4'b1000;
            end
            step(m, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 5), d);
        end
        idle();
        idle();

        v = m_victim();
        oh = '0;
        oh[v] = 1'b1;
        fill({$urandom, $urandom});
        step(oh, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        step(oh, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        mon_en = 1'b0;
        #1 check("pre_reset_hit_comb", hit_c, 1'b1);
        check("pre_reset_hit_reg", hit_r, 1'b1);
        reset = 1'b0;
        #1 check("async_reset_valids", valids_r, 8'h00);
        check("async_reset_valids_comb", valids_c, 8'h00);
        check("async_reset_hit_reg", hit_r, 1'b0);
        check("async_reset_hit_comb", hit_c, 1'b0);
        check("async_reset_ppn", ppn_r, 44'h0);
        check("async_reset_victim", victim_r, 8'h01);
        comb_q.delete();
        reg_q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
